// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_EMPTY = 1'b0,
        ARB_HELD  = 1'b1
    } wb_arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_MDU  = 2'd2
    } wb_grant_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a completed MDU result (rd + data).
// Load wins over clear; a cleared entry reads back as rd 0 / data 0.
module wb_hold_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [4:0]      load_rd,
    input  logic [XLEN-1:0] load_data,
    output logic            full,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] data
);

    logic            full_q, full_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    // Next-entry selection
    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            rd_d   = load_rd;
            data_d = load_data;
        end else if (clear) begin
            full_d = 1'b0;
            rd_d   = REG_ZERO;
            data_d = {XLEN{1'b0}};
        end else begin
            full_d = full_q;
        end
    end

    // Entry registers
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            rd_q   <= REG_ZERO;
            data_q <= {XLEN{1'b0}};
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign rd   = rd_q;
    assign data = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline WB and the MDU.
// Optional performance counters are enabled with the WB_ARB_PERF_EN macro.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_result,
    output logic            pipe_stall,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_result,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pending_valid,
    output logic [4:0]      pending_rd,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_kill_cnt,
`endif
    output logic            mdu_kill
);

    localparam int                 CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);

    wb_arb_state_t    state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    wb_grant_t        grant;
    logic             pipe_req;
    logic             hold_load, hold_clear, hold_full;
    logic [4:0]       hold_rd;
    logic [XLEN-1:0]  hold_data;

    assign pipe_req = pipe_we & (pipe_rd != REG_ZERO);

    wb_hold_buf #(.XLEN(XLEN)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_rd   (mdu_rd),
        .load_data (mdu_result),
        .full      (hold_full),
        .rd        (hold_rd),
        .data      (hold_data)
    );

    // Next-state, grant and pulse decisions; reset suppresses any write
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grant        = GRANT_NONE;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        pipe_stall   = 1'b0;
        mdu_kill     = 1'b0;
        if (reset) begin
            state_d      = ARB_EMPTY;
            starve_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ARB_EMPTY: begin
                    grant = pipe_req ? GRANT_PIPE : GRANT_NONE;
                    // x0 results are accepted and silently dropped
                    if (mdu_valid && (mdu_rd != REG_ZERO)) begin
                        hold_load    = 1'b1;
                        state_d      = ARB_HELD;
                        starve_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ARB_EMPTY;
                    end
                end
                ARB_HELD: begin
                    if (!pipe_req) begin
                        grant        = GRANT_MDU;
                        hold_clear   = 1'b1;
                        state_d      = ARB_EMPTY;
                        starve_cnt_d = {CNT_W{1'b0}};
                    end else if (starve_cnt_q == STARVE_LIM) begin
                        grant        = GRANT_MDU;
                        pipe_stall   = 1'b1;
                        hold_clear   = 1'b1;
                        state_d      = ARB_EMPTY;
                        starve_cnt_d = {CNT_W{1'b0}};
                    end else if (pipe_rd == hold_rd) begin
                        // Younger pipeline write to the same rd makes the held value dead
                        grant        = GRANT_PIPE;
                        mdu_kill     = 1'b1;
                        hold_clear   = 1'b1;
                        state_d      = ARB_EMPTY;
                        starve_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        grant        = GRANT_PIPE;
                        starve_cnt_d = starve_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    hold_clear   = 1'b1;
                    state_d      = ARB_EMPTY;
                    starve_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Write-port mux
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = {XLEN{1'b0}};
        case (grant)
            GRANT_PIPE: begin
                rf_we    = 1'b1;
                rf_waddr = pipe_rd;
                rf_wdata = pipe_result;
            end
            GRANT_MDU: begin
                rf_we    = 1'b1;
                rf_waddr = hold_rd;
                rf_wdata = hold_data;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    // State and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_EMPTY;
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mdu_ready     = (state_q == ARB_EMPTY);
    assign pending_valid = hold_full;
    assign pending_rd    = hold_rd;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    // Saturating event counters
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_kill_d  = perf_kill_q;
        if (pipe_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (mdu_kill && (perf_kill_q != 32'hFFFF_FFFF)) begin
            perf_kill_d = perf_kill_q + 32'd1;
        end else begin
            perf_kill_d = perf_kill_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= 32'd0;
            perf_kill_q  <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_kill_cnt  = perf_kill_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int SM   = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_result;
    logic            pipe_stall;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_result;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pending_valid;
    logic [4:0]      pending_rd;
    logic            mdu_kill;
`ifdef WB_ARB_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_kill_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the optional held result and how often it has lost in a row
    bit          m_held;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_losses;
    longint      m_stalls;
    longint      m_kills;

    wb_port_arbiter #(.STARVE_MAX(SM), .XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_we       (pipe_we),
        .pipe_rd       (pipe_rd),
        .pipe_result   (pipe_result),
        .pipe_stall    (pipe_stall),
        .mdu_valid     (mdu_valid),
        .mdu_ready     (mdu_ready),
        .mdu_rd        (mdu_rd),
        .mdu_result    (mdu_result),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pending_valid (pending_valid),
        .pending_rd    (pending_rd),
`ifdef WB_ARB_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_kill_cnt (perf_kill_cnt),
`endif
        .mdu_kill      (mdu_kill)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit we, input logic [4:0] prd, input logic [31:0] pres,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mres);
        @(negedge clk);
        reset       = rst;
        pipe_we     = we;
        pipe_rd     = prd;
        pipe_result = pres;
        mdu_valid   = mv;
        mdu_rd      = mrd;
        mdu_result  = mres;
        #1;
    endtask

    // Compare the current outputs against the model, then advance the model to the next edge
    task automatic model_check();
        bit          req, e_we, e_stall, e_kill;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        req     = pipe_we && (pipe_rd != 5'd0);
        e_we    = 1'b0;
        e_stall = 1'b0;
        e_kill  = 1'b0;
        e_addr  = 5'd0;
        e_data  = 32'd0;
`ifdef WB_ARB_PERF_EN
        check_eq("perf_stall", perf_stall_cnt, 32'(m_stalls));
        check_eq("perf_kill", perf_kill_cnt, 32'(m_kills));
`endif
        if (reset) begin
            check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
            check_eq("rst_kill", {31'd0, mdu_kill}, 32'd0);
            m_held   = 1'b0;
            m_losses = 0;
            m_stalls = 0;
            m_kills  = 0;
        end else begin
            check_eq("mdu_ready", {31'd0, mdu_ready}, {31'd0, !m_held});
            check_eq("pending_valid", {31'd0, pending_valid}, {31'd0, m_held});
            if (m_held) check_eq("pending_rd", {27'd0, pending_rd}, {27'd0, m_rd});
            if (!m_held) begin
                if (req) begin
                    e_we = 1'b1; e_addr = pipe_rd; e_data = pipe_result;
                end
                if (mdu_valid && mdu_rd != 5'd0) begin
                    m_held = 1'b1; m_rd = mdu_rd; m_data = mdu_result; m_losses = 0;
                end
            end else if (!req || m_losses == SM) begin
                e_we = 1'b1; e_addr = m_rd; e_data = m_data;
                e_stall = req;
                m_held = 1'b0;
            end else begin
                e_we = 1'b1; e_addr = pipe_rd; e_data = pipe_result;
                if (pipe_rd == m_rd) begin
                    e_kill = 1'b1;
                    m_held = 1'b0;
                end else begin
                    m_losses++;
                end
            end
            check_eq("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            check_eq("pipe_stall", {31'd0, pipe_stall}, {31'd0, e_stall});
            check_eq("mdu_kill", {31'd0, mdu_kill}, {31'd0, e_kill});
            if (e_we) begin
                check_eq("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
                check_eq("rf_wdata", rf_wdata, e_data);
            end
            m_stalls += longint'(e_stall);
            m_kills  += longint'(e_kill);
        end
    endtask

    task automatic step(input bit rst, input bit we, input logic [4:0] prd, input logic [31:0] pres,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] mres);
        drive(rst, we, prd, pres, mv, mrd, mres);
        model_check();
    endtask

    initial begin
        logic [4:0] starve_addr [6];
        logic [0:0] starve_stall [6];
        starve_addr  = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd3, 5'd9};
        starve_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        m_held = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_losses = 0; m_stalls = 0; m_kills = 0;
        reset = 1'b1; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_result = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_result = 32'd0;

        // Reset held with an MDU result offered
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("reset_pending", {31'd0, pending_valid}, 32'd0);
        check_eq("reset_ready", {31'd0, mdu_ready}, 32'd1);
        check_eq("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check_eq("reset_pending_rd", {27'd0, pending_rd}, 32'd0);
        model_check();

        // Idle port: MDU result written one cycle after acceptance
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("idle_we", {31'd0, rf_we}, 32'd1);
        check_eq("idle_waddr", {27'd0, rf_waddr}, 32'd7);
        check_eq("idle_wdata", rf_wdata, 32'hDEAD_BEEF);
        model_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("idle_pending_after", {31'd0, pending_valid}, 32'd0);
        model_check();

        // Starvation: four pipeline wins, then a forced MDU grant with stall
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0333);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 5'd9, 32'h900 + 32'(i), 1'b0, 5'd0, 32'd0);
            check_eq("starve_waddr", {27'd0, rf_waddr}, {27'd0, starve_addr[i]});
            check_eq("starve_stall", {31'd0, pipe_stall}, {31'd0, starve_stall[i]});
            model_check();
        end

        // WAW kill
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hBAD0_BAD0);
        drive(1'b0, 1'b1, 5'd12, 32'h1, 1'b0, 5'd0, 32'd0);
        check_eq("waw_wdata", rf_wdata, 32'h1);
        check_eq("waw_kill", {31'd0, mdu_kill}, 32'd1);
        model_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("waw_pending", {31'd0, pending_valid}, 32'd0);
        check_eq("waw_no_mdu_write", {31'd0, rf_we}, 32'd0);
        model_check();

        // x0 handling
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("x0_drop_pending", {31'd0, pending_valid}, 32'd0);
        check_eq("x0_drop_we", {31'd0, rf_we}, 32'd0);
        model_check();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666);
        drive(1'b0, 1'b1, 5'd0, 32'hAAAA, 1'b0, 5'd0, 32'd0);
        check_eq("x0_pipe_mdu_addr", {27'd0, rf_waddr}, 32'd6);
        check_eq("x0_pipe_no_stall", {31'd0, pipe_stall}, 32'd0);
        model_check();

        // Reset while holding: no write to x4
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("rsthold_no_write", {31'd0, rf_we}, 32'd0);
        model_check();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("rsthold_pending", {31'd0, pending_valid}, 32'd0);
        check_eq("rsthold_we", {31'd0, rf_we}, 32'd0);
`ifdef WB_ARB_PERF_EN
        check_eq("rsthold_perf_stall", perf_stall_cnt, 32'd0);
        check_eq("rsthold_perf_kill", perf_kill_cnt, 32'd0);
`endif
        model_check();

        // Random traffic with narrow rd ranges to provoke collisions and starvation
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (result-mux output) and the multi-cycle MUL/DIV unit (MDU).
- Holds one completed MDU result in a holding register and gives the pipeline priority.
- Guarantees MDU forward progress with a starvation limit that stalls the pipeline for one cycle.
- Sits between the WB-stage result mux, the MDU and the register file; also exports the pending MDU destination to the hazard unit.

Parameters:
- STARVE_MAX, 4, consecutive cycles a held MDU result may lose to the pipeline before a forced MDU grant (legal range 1..15).
- XLEN, 32, data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline WB wants to write
- pipe_rd  in  5  pipeline destination register
- pipe_result  in  XLEN  WB result-mux output (ALU, memory or PC+4)
- pipe_stall  out  1  pipeline must hold WB and all earlier stages this cycle
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  holding register can accept
- mdu_rd  in  5  MDU destination register
- mdu_result  in  XLEN  MDU result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- pending_valid  out  1  MDU result held and not yet written
- pending_rd  out  5  rd of the held result (hazard unit uses it for RAW/WAW stalls)
- mdu_kill  out  1  held result discarded this cycle (younger write to same rd)

Behaviour:
- State: FSM wb_arb_state_t {ARB_EMPTY, ARB_HELD}; holding register (rd, data); starve_cnt, width $clog2(STARVE_MAX+1).
- Reset: state ARB_EMPTY, starve_cnt 0, held rd/data 0.
  - Resulting outputs: rf_we 0, pipe_stall 0, mdu_ready 1, pending_valid 0, pending_rd 0, mdu_kill 0.
- pipe_req = pipe_we & (pipe_rd != 0). Writes to x0 never use the port.
- mdu_ready = (state == ARB_EMPTY). There is no bypass: an MDU result is written at the earliest one cycle after acceptance.
- ARB_EMPTY:
  - rf_we = pipe_req, waddr = pipe_rd, wdata = pipe_result.
  - On mdu_valid with mdu_rd != 0: load the holding register and go to ARB_HELD, starve_cnt 0.
  - On mdu_valid with mdu_rd == 0: accept and drop; stay in ARB_EMPTY.
- ARB_HELD, no pipe_req: grant MDU (rf_we 1, held rd/data); go to ARB_EMPTY, starve_cnt 0.
- ARB_HELD, pipe_req and starve_cnt < STARVE_MAX: grant pipeline, starve_cnt + 1.
- ARB_HELD, pipe_req and starve_cnt == STARVE_MAX:
  - Grant MDU and assert pipe_stall for exactly that cycle.
  - Go to ARB_EMPTY, starve_cnt 0.
  - Pipeline re-presents the same write next cycle and wins, since the state is now empty.
- WAW kill: in ARB_HELD, if the pipeline is granted and pipe_rd == held rd:
  - The younger pipeline write wins.
  - Pulse mdu_kill for 1 cycle, go to ARB_EMPTY, starve_cnt 0.
- All outputs other than state registers are combinational from current state and inputs. A grant takes effect at the same clock edge as the register-file write.
- Reset asserted in ARB_HELD discards the held result with no write. Reset overrides mdu_valid in the same cycle.
- pipe_stall is never asserted in ARB_EMPTY.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined, adds:
  - Output perf_stall_cnt [31:0]: increments each cycle pipe_stall is 1.
  - Output perf_kill_cnt [31:0]: increments each cycle mdu_kill is 1.
  - Both counters reset to 0 and saturate at all-ones.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Decomposition:
- Add to Pkg:
  - wb_arb_state_t
  - wb_grant_t {GRANT_NONE, GRANT_PIPE, GRANT_MDU}, used internally for the write-port mux select
  - constant REG_ZERO = 5'd0
- One natural sub-module: wb_hold_buf, a one-entry rd/data holding register with load/clear/full.

Test Plan:
- Reset: hold reset 2 cycles with mdu_valid=1, rd=5 -> after release pending_valid 0, mdu_ready 1, rf_we 0.
- Idle-port grant: MDU rd=7 data 0xDEAD_BEEF while pipe_we=0 -> next cycle rf_we 1, waddr 7, wdata 0xDEADBEEF; following cycle pending_valid 0.
- Starvation (STARVE_MAX=4): MDU rd=3 held, pipe writes rd=9 every cycle:
  - Cycles 1-4: port goes to pipe, rd=9.
  - Cycle 5: rf_waddr 3 with pipe_stall 1.
  - Cycle 6: pipe rd=9 written.
- WAW kill: held rd=12, pipe writes rd=12 data 0x1 -> rf_wdata 0x1, mdu_kill 1, pending_valid 0 next cycle; the MDU value is never written.
- x0 handling: mdu_rd=0 accepted -> no held state, no write. pipe_we=1 with pipe_rd=0 while held -> MDU granted, starve_cnt unchanged at 0.
- Reset mid-hold: held rd=4, assert reset -> no write to x4, pending_valid 0. With WB_ARB_PERF_EN, perf counters read 0.
